line_draw_engine: RTL and testbench

//  Memory-mapped Bresenham line accelerator. Sits downstream of the multicycle

---
 rtl/line_draw_pkg.sv | 19 +
 rtl/line_draw_if.sv | 26 ++
 rtl/bresenham_step.sv | 43 ++++
 rtl/line_draw_engine.sv | 157 +++++++++++++++
 tb/tb_line_draw_engine.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/line_draw_pkg.sv
// Shared widths, register offsets and FSM encoding for the Bresenham line engine.
package line_draw_pkg;

  localparam int unsigned XW   = 8;
  localparam int unsigned YW   = 7;
  localparam int unsigned CW   = 3;
  localparam int unsigned ERRW = ((XW > YW) ? XW : YW) + 2;

  localparam logic [2:0] RegX0     = 3'd0;
  localparam logic [2:0] RegY0     = 3'd1;
  localparam logic [2:0] RegX1     = 3'd2;
  localparam logic [2:0] RegY1     = 3'd3;
  localparam logic [2:0] RegColor  = 3'd4;
  localparam logic [2:0] RegGo     = 3'd5;
  localparam logic [2:0] RegStatus = 3'd6;

  typedef enum logic [1:0] {StIdle, StSetup, StPlot, StDone} state_e;

endpackage

// File: rtl/line_draw_if.sv
// Processor register bus plus pixel-stream handshake toward the framebuffer.
interface line_draw_if;
  import line_draw_pkg::*;

  logic [2:0]    ADDR;
  logic [15:0]   DOUT;
  logic          W;
  logic [15:0]   RDATA;
  logic [XW-1:0] plot_x;
  logic [YW-1:0] plot_y;
  logic [CW-1:0] plot_color;
  logic          plot_valid;
  logic          plot_ready;
  logic          done;

  modport slave (
    input  ADDR, DOUT, W, plot_ready,
    output RDATA, plot_x, plot_y, plot_color, plot_valid, done
  );

  modport master (
    output ADDR, DOUT, W, plot_ready,
    input  RDATA, plot_x, plot_y, plot_color, plot_valid, done
  );

endinterface

// File: rtl/bresenham_step.sv
// One combinational Bresenham iteration; both axis updates are based on the incoming err.
module bresenham_step
  import line_draw_pkg::*;
(
  input  logic [XW-1:0]          x_i,
  input  logic [YW-1:0]          y_i,
  input  logic signed [ERRW-1:0] err_i,
  input  logic signed [ERRW-1:0] dx_i,
  input  logic signed [ERRW-1:0] dy_i,
  input  logic                   sx_i,
  input  logic                   sy_i,
  output logic [XW-1:0]          x_o,
  output logic [YW-1:0]          y_o,
  output logic signed [ERRW-1:0] err_o
);

  localparam logic [XW-1:0] XOne = XW'(1);
  localparam logic [YW-1:0] YOne = YW'(1);

  // One extra bit so 2*err cannot overflow.
  logic signed [ERRW:0] e2, dx_ext, dy_ext;
  logic                 step_x, step_y;

  always_comb begin
    e2     = {err_i, 1'b0};
    dx_ext = {dx_i[ERRW-1], dx_i};
    dy_ext = {dy_i[ERRW-1], dy_i};
    step_x = (e2 >= dy_ext);
    step_y = (e2 <= dx_ext);
    x_o    = x_i;
    y_o    = y_i;
    err_o  = err_i;
    if (step_x) begin
      err_o = err_o + dy_i;
      x_o   = sx_i ? (x_i - XOne) : (x_i + XOne);
    end
    if (step_y) begin
      err_o = err_o + dx_i;
      y_o   = sy_i ? (y_i - YOne) : (y_i + YOne);
    end
  end

endmodule

// File: rtl/line_draw_engine.sv
// Memory-mapped Bresenham line accelerator: register file, control FSM and pixel stream.
module line_draw_engine
  import line_draw_pkg::*;
(
  input logic        Clock,
  input logic        Resetn,
  line_draw_if.slave bus
);

  state_e state_q, state_d;
  logic   busy, wr_en, go, at_end, unused_dout;

  logic [XW-1:0] x0_q, x0_d, x1_q, x1_d, x_q, x_d, step_x, adx;
  logic [YW-1:0] y0_q, y0_d, y1_q, y1_d, y_q, y_d, step_y, ady;
  logic [CW-1:0] color_q, color_d;
  logic signed [ERRW-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d, step_err;
  logic          sx_q, sx_d, sy_q, sy_d, sticky_q, sticky_d;
  logic [15:0]   rdata_q, rdata_d;

  assign wr_en       = bus.W && (state_q == StIdle);
  assign go          = wr_en && (bus.ADDR == RegGo);
  assign at_end      = (x_q == x1_q) && (y_q == y1_q);
  assign adx         = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
  assign ady         = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
  assign unused_dout = ^bus.DOUT[15:8];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (go) state_d = StSetup;
      StSetup: state_d = StPlot;
      StPlot:  if (bus.plot_ready && at_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy           = (state_q != StIdle);
    bus.plot_valid = (state_q == StPlot);
    bus.done       = (state_q == StDone);
  end

  always_comb begin
    x0_d     = x0_q;
    y0_d     = y0_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    color_d  = color_q;
    sticky_d = sticky_q;
    if (wr_en) begin
      case (bus.ADDR)
        RegX0:    x0_d     = bus.DOUT[XW-1:0];
        RegY0:    y0_d     = bus.DOUT[YW-1:0];
        RegX1:    x1_d     = bus.DOUT[XW-1:0];
        RegY1:    y1_d     = bus.DOUT[YW-1:0];
        RegColor: color_d  = bus.DOUT[CW-1:0];
        RegGo:    sticky_d = 1'b0;
        default:  ;
      endcase
    end
    if (state_q == StDone) sticky_d = 1'b1;
  end

  bresenham_step u_step (
    .x_i   (x_q),
    .y_i   (y_q),
    .err_i (err_q),
    .dx_i  (dx_q),
    .dy_i  (dy_q),
    .sx_i  (sx_q),
    .sy_i  (sy_q),
    .x_o   (step_x),
    .y_o   (step_y),
    .err_o (step_err)
  );

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    err_d = err_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    sx_d  = sx_q;
    sy_d  = sy_q;
    if (state_q == StSetup) begin
      x_d   = x0_q;
      y_d   = y0_q;
      dx_d  = ERRW'(adx);
      dy_d  = -$signed(ERRW'(ady));
      err_d = ERRW'(adx) - ERRW'(ady);
      sx_d  = (x1_q < x0_q);
      sy_d  = (y1_q < y0_q);
    end else if ((state_q == StPlot) && bus.plot_ready && !at_end) begin
      x_d   = step_x;
      y_d   = step_y;
      err_d = step_err;
    end
  end

  always_comb begin
    case (bus.ADDR)
      RegX0:     rdata_d = 16'(x0_q);
      RegY0:     rdata_d = 16'(y0_q);
      RegX1:     rdata_d = 16'(x1_q);
      RegY1:     rdata_d = 16'(y1_q);
      RegColor:  rdata_d = 16'(color_q);
      RegStatus: rdata_d = {14'd0, sticky_q, busy};
      default:   rdata_d = 16'd0;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '0;
      sticky_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      err_q    <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      x1_q     <= x1_d;
      y1_q     <= y1_d;
      color_q  <= color_d;
      sticky_q <= sticky_d;
      x_q      <= x_d;
      y_q      <= y_d;
      err_q    <= err_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.RDATA      = rdata_q;
  assign bus.plot_x     = x_q;
  assign bus.plot_y     = y_q;
  assign bus.plot_color = color_q;

endmodule

// File: tb/tb_line_draw_engine.sv
// Directed bench: table of lines with hand-derived pixel lists, plus a mid-line reset sequence.
module tb_line_draw_engine;
  import line_draw_pkg::*;

  logic Clock;
  logic Resetn;
  line_draw_if bus ();

  line_draw_engine dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0]      x0;
    logic [6:0]      y0;
    logic [7:0]      x1;
    logic [6:0]      y1;
    logic [2:0]      col;
    logic [3:0]      n;
    logic [3:0]      stall_at;
    logic [3:0]      stall_len;
    logic            inject;
    logic [7:0][7:0] ex;
    logic [7:0][6:0] ey;
  } vec_t;

  localparam int NVec = 7;
  vec_t vec [NVec];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int x0, input int y0, input int x1, input int y1,
                         input int col, input int sa, input int sl, input bit inj);
    vec[i]           = '0;
    vec[i].x0        = 8'(x0);
    vec[i].y0        = 7'(y0);
    vec[i].x1        = 8'(x1);
    vec[i].y1        = 7'(y1);
    vec[i].col       = 3'(col);
    vec[i].stall_at  = 4'(sa);
    vec[i].stall_len = 4'(sl);
    vec[i].inject    = inj;
  endtask

  task automatic add_px(input int i, input int x, input int y);
    vec[i].ex[vec[i].n] = 8'(x);
    vec[i].ey[vec[i].n] = 7'(y);
    vec[i].n            = vec[i].n + 4'd1;
  endtask

  task automatic wr(input logic [2:0] a, input int d);
    @(negedge Clock);
    bus.ADDR = a;
    bus.DOUT = 16'(d);
    bus.W    = 1'b1;
    @(negedge Clock);
    bus.W    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output int d);
    @(negedge Clock);
    bus.ADDR = a;
    bus.W    = 1'b0;
    @(negedge Clock);
    d = int'(bus.RDATA);
  endtask

  task automatic run_line(input int i);
    int acc, first, stalls, done_cyc, n, r;
    bit rdy;
    n        = int'(vec[i].n);
    acc      = 0;
    first    = -1;
    stalls   = 0;
    done_cyc = -1;
    wr(RegX0, int'(vec[i].x0));
    wr(RegY0, int'(vec[i].y0));
    wr(RegX1, int'(vec[i].x1));
    wr(RegY1, int'(vec[i].y1));
    wr(RegColor, int'(vec[i].col));
    wr(RegGo, 0);
    // cyc 1 is the cycle right after the GO write was captured
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc > 1) @(negedge Clock);
      rdy = !((acc == int'(vec[i].stall_at)) && (stalls < int'(vec[i].stall_len)));
      bus.plot_ready = rdy;
      if (vec[i].inject) begin
        if (cyc == 3) begin
          bus.ADDR = RegX1; bus.DOUT = 16'd0; bus.W = 1'b1;
        end else if (cyc == 4) begin
          bus.ADDR = RegGo;
        end else if (cyc == 5) begin
          bus.W = 1'b0; bus.ADDR = RegStatus;
        end else if (cyc == 6) begin
          chk("busy_status", int'(bus.RDATA[0]), 1);
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        chk("valid_during_done", int'(bus.plot_valid), 0);
        break;
      end
      if (bus.plot_valid) begin
        if (first < 0) first = cyc;
        if (acc < n) begin
          chk("pix_x", int'(bus.plot_x), int'(vec[i].ex[acc]));
          chk("pix_y", int'(bus.plot_y), int'(vec[i].ey[acc]));
          chk("pix_color", int'(bus.plot_color), int'(vec[i].col));
        end else begin
          chk("extra_pixel", acc, n - 1);
        end
        if (rdy) acc++;
        else stalls++;
      end
    end
    bus.W          = 1'b0;
    bus.plot_ready = 1'b1;
    chk("first_valid_latency", first, 2);
    chk("pixel_count", acc, n);
    chk("done_cycle", done_cyc, 2 + n + int'(vec[i].stall_len));
    @(negedge Clock);
    chk("done_pulse_width", int'(bus.done), 0);
    chk("idle_valid", int'(bus.plot_valid), 0);
    rd(RegStatus, r);
    chk("status_after_line", r, 2);
  endtask

  initial begin
    int r, acc;
    bit hit;
    Resetn         = 1'b0;
    bus.ADDR       = 3'd0;
    bus.DOUT       = 16'd0;
    bus.W          = 1'b0;
    bus.plot_ready = 1'b1;

    set_vec(0, 0, 0, 3, 0, 5, 15, 0, 0);
    add_px(0, 0, 0); add_px(0, 1, 0); add_px(0, 2, 0); add_px(0, 3, 0);
    set_vec(1, 5, 5, 3, 0, 2, 15, 0, 0);
    add_px(1, 5, 5); add_px(1, 5, 4); add_px(1, 4, 3);
    add_px(1, 4, 2); add_px(1, 3, 1); add_px(1, 3, 0);
    set_vec(2, 7, 7, 7, 7, 7, 15, 0, 0);
    add_px(2, 7, 7);
    set_vec(3, 0, 0, 2, 2, 1, 1, 3, 0);
    add_px(3, 0, 0); add_px(3, 1, 1); add_px(3, 2, 2);
    set_vec(4, 1, 2, 6, 4, 6, 15, 0, 1);
    add_px(4, 1, 2); add_px(4, 2, 2); add_px(4, 3, 3);
    add_px(4, 4, 3); add_px(4, 5, 4); add_px(4, 6, 4);
    set_vec(5, 4, 1, 0, 1, 3, 15, 0, 0);
    add_px(5, 4, 1); add_px(5, 3, 1); add_px(5, 2, 1); add_px(5, 1, 1); add_px(5, 0, 1);
    set_vec(6, 2, 6, 2, 3, 4, 15, 0, 0);
    add_px(6, 2, 6); add_px(6, 2, 5); add_px(6, 2, 4); add_px(6, 2, 3);

    repeat (3) @(negedge Clock);
    chk("reset_valid", int'(bus.plot_valid), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_rdata", int'(bus.RDATA), 0);
    chk("reset_plot_x", int'(bus.plot_x), 0);
    Resetn = 1'b1;
    rd(RegStatus, r);
    chk("reset_status", r, 0);

    for (int i = 0; i < NVec; i++) begin
      run_line(i);
      if (vec[i].inject) begin
        rd(RegX1, r);
        chk("x1_write_ignored", r, int'(vec[i].x1));
      end
    end

    // Ten-pixel line (2,3)->(11,5), reset asserted while the third pixel is offered.
    wr(RegX0, 2); wr(RegY0, 3); wr(RegX1, 11); wr(RegY1, 5); wr(RegColor, 5); wr(RegGo, 0);
    acc = 0;
    hit = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge Clock);
      if (bus.plot_valid) begin
        if (acc == 2) begin
          Resetn = 1'b0;
          #1;
          chk("async_reset_valid", int'(bus.plot_valid), 0);
          chk("async_reset_done", int'(bus.done), 0);
          hit = 1'b1;
          break;
        end
        acc++;
      end
    end
    chk("reached_third_pixel", int'(hit), 1);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clock);
      chk("post_reset_no_pixel", int'(bus.plot_valid), 0);
      chk("post_reset_no_done", int'(bus.done), 0);
    end
    for (int a = 0; a < 5; a++) begin
      rd(3'(a), r);
      chk("post_reset_reg", r, 0);
    end
    rd(RegStatus, r);
    chk("post_reset_status", r, 0);
    run_line(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
